// File: rtl/score_display_decoder.sv
// Validates and debounces the one-hot score digit lines, keeps ones/tens BCD digits and
// drives a multiplexed active-low 7-segment display. Define SCORE_TENS_EN for the tens digit.
module score_display_decoder #(
  parameter int unsigned REFRESH_DIV   = 100000,
  parameter int unsigned STABLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       isactive_0,
  input  logic       isactive_1,
  input  logic       isactive_2,
  input  logic       isactive_3,
  input  logic       isactive_4,
  input  logic       isactive_5,
  input  logic       isactive_6,
  input  logic       isactive_7,
  input  logic       isactive_8,
  input  logic       isactive_9,
  output logic [3:0] digit_ones,
  output logic [3:0] digit_tens,
  output logic       score_inc,
  output logic       onehot_err,
  output logic       seq_err,
  output logic [6:0] seg,
  output logic [1:0] an
);

  logic [9:0] in_q, in_d;
  logic [3:0] cand_q, cand_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] ones_q, ones_d;
  logic       inc_q, inc_d;
  logic       oerr_q, oerr_d;
  logic       serr_q, serr_d;
  logic [6:0] seg_q, seg_d;
  logic [1:0] an_q, an_d;

  logic       valid;
  logic [3:0] code;
  logic [3:0] nset;
  logic [3:0] ones_succ;
  logic [3:0] seg_sel;

`ifdef SCORE_TENS_EN
  localparam int unsigned RW = $clog2(REFRESH_DIV);

  typedef enum logic {SLOT_ONES, SLOT_TENS} slot_t;

  logic [3:0]    tens_q, tens_d;
  logic [RW-1:0] refresh_q, refresh_d;
  slot_t         slot_q, slot_d;
`endif

  function automatic logic [6:0] pattern(input logic [3:0] d);
    case (d)
      4'd0:    pattern = 7'b1000000;
      4'd1:    pattern = 7'b1111001;
      4'd2:    pattern = 7'b0100100;
      4'd3:    pattern = 7'b0110000;
      4'd4:    pattern = 7'b0011001;
      4'd5:    pattern = 7'b0010010;
      4'd6:    pattern = 7'b0000010;
      4'd7:    pattern = 7'b1111000;
      4'd8:    pattern = 7'b0000000;
      4'd9:    pattern = 7'b0010000;
      default: pattern = 7'b1111111;
    endcase
  endfunction

  always_comb begin
    in_d = {isactive_9, isactive_8, isactive_7, isactive_6, isactive_5,
            isactive_4, isactive_3, isactive_2, isactive_1, isactive_0};

    nset = '0;
    code = '0;
    for (int unsigned i = 0; i < 10; i++) begin
      if (in_q[i]) begin
        nset = nset + 4'd1;
        code = 4'(i);
      end
    end
    valid     = (nset == 4'd1);
    ones_succ = (ones_q == 4'd9) ? 4'd0 : ones_q + 4'd1;

    cand_d = cand_q;
    cnt_d  = cnt_q;
    ones_d = ones_q;
    inc_d  = 1'b0;
    oerr_d = !valid;
    serr_d = serr_q;
`ifdef SCORE_TENS_EN
    tens_d = tens_q;
`endif

    if (!valid || code == ones_q) begin
      cnt_d = '0;
    end else begin
      if (code == cand_q) begin
        cnt_d = (cnt_q == 4'hF) ? cnt_q : cnt_q + 4'd1;
      end else begin
        cand_d = code;
        cnt_d  = 4'd1;
      end
      // Acceptance fires on the same edge the count reaches the threshold.
      if (cnt_d == 4'(STABLE_CYCLES)) begin
        cnt_d  = '0;
        ones_d = code;
        if (code == ones_succ) begin
          inc_d = 1'b1;
`ifdef SCORE_TENS_EN
          if (ones_q == 4'd9) tens_d = (tens_q == 4'd9) ? 4'd0 : tens_q + 4'd1;
`endif
        end else if (code == 4'd0) begin
`ifdef SCORE_TENS_EN
          tens_d = '0;
`endif
        end else begin
          serr_d = 1'b1;
        end
      end
    end

`ifdef SCORE_TENS_EN
    slot_d    = slot_q;
    refresh_d = refresh_q + RW'(1);
    if (refresh_q == RW'(REFRESH_DIV - 1)) begin
      refresh_d = '0;
      slot_d    = (slot_q == SLOT_ONES) ? SLOT_TENS : SLOT_ONES;
    end
    // New slot, but digits as they stood before this edge's update.
    seg_sel = (slot_d == SLOT_TENS) ? tens_q : ones_q;
    an_d    = (slot_d == SLOT_TENS) ? 2'b01 : 2'b10;
`else
    seg_sel = ones_q;
    an_d    = 2'b10;
`endif
    seg_d = pattern(seg_sel);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      in_q      <= '0;
      cand_q    <= '0;
      cnt_q     <= '0;
      ones_q    <= '0;
      inc_q     <= 1'b0;
      oerr_q    <= 1'b0;
      serr_q    <= 1'b0;
      seg_q     <= 7'b1000000;
      an_q      <= 2'b10;
`ifdef SCORE_TENS_EN
      tens_q    <= '0;
      refresh_q <= '0;
      slot_q    <= SLOT_ONES;
`endif
    end else begin
      in_q      <= in_d;
      cand_q    <= cand_d;
      cnt_q     <= cnt_d;
      ones_q    <= ones_d;
      inc_q     <= inc_d;
      oerr_q    <= oerr_d;
      serr_q    <= serr_d;
      seg_q     <= seg_d;
      an_q      <= an_d;
`ifdef SCORE_TENS_EN
      tens_q    <= tens_d;
      refresh_q <= refresh_d;
      slot_q    <= slot_d;
`endif
    end
  end

  assign digit_ones = ones_q;
`ifdef SCORE_TENS_EN
  assign digit_tens = tens_q;
`else
  assign digit_tens = '0;
`endif
  assign score_inc  = inc_q;
  assign onehot_err = oerr_q;
  assign seq_err    = serr_q;
  assign seg        = seg_q;
  assign an         = an_q;

endmodule

// File: tb/tb_score_display_decoder.sv
// Bench for score_display_decoder: vector table, hand sequences and randomized traffic
// checked every cycle against a run-length based reference model.
module tb_score_display_decoder;

  localparam int DIV = 4;
  localparam int STB = 2;
`ifdef SCORE_TENS_EN
  localparam int TE = 1;
`else
  localparam int TE = 0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [9:0] act = '0;
  logic [3:0] digit_ones, digit_tens;
  logic       score_inc, onehot_err, seq_err;
  logic [6:0] seg;
  logic [1:0] an;

  int errors = 0;
  int checks = 0;
  int inc_cnt = 0;
  int oerr_cnt = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  score_display_decoder #(.REFRESH_DIV(DIV), .STABLE_CYCLES(STB)) dut (
    .clk(clk), .rst(rst),
    .isactive_0(act[0]), .isactive_1(act[1]), .isactive_2(act[2]), .isactive_3(act[3]),
    .isactive_4(act[4]), .isactive_5(act[5]), .isactive_6(act[6]), .isactive_7(act[7]),
    .isactive_8(act[8]), .isactive_9(act[9]),
    .digit_ones(digit_ones), .digit_tens(digit_tens), .score_inc(score_inc),
    .onehot_err(onehot_err), .seq_err(seq_err), .seg(seg), .an(an)
  );

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic logic [6:0] pat(input int d);
    case (d)
      0: pat = 7'b1000000;  1: pat = 7'b1111001;  2: pat = 7'b0100100;
      3: pat = 7'b0110000;  4: pat = 7'b0011001;  5: pat = 7'b0010010;
      6: pat = 7'b0000010;  7: pat = 7'b1111000;  8: pat = 7'b0000000;
      default: pat = 7'b0010000;
    endcase
  endfunction

  // Reference model: a digit is accepted once it has been the sampled valid code for
  // STB consecutive samples while differing from the displayed ones digit.
  int         m_ones = 0, m_tens = 0, m_inc = 0, m_oerr = 0, m_serr = 0;
  int         m_slot = 0, m_ref = 0, m_run = 0, m_last = 0;
  bit         m_lastv = 1'b0;
  logic [9:0] m_inq = '0;
  logic [6:0] m_seg = 7'b1000000;
  logic [1:0] m_an = 2'b10;

  always @(posedge clk) begin
    if (rst) begin
      m_ones = 0; m_tens = 0; m_inc = 0; m_oerr = 0; m_serr = 0;
      m_slot = 0; m_ref = 0; m_run = 0; m_lastv = 1'b0; m_inq = '0;
      m_seg = 7'b1000000; m_an = 2'b10;
    end else begin
      int code;
      bit v;
      code = 0;
      v = ($countones(m_inq) == 1);
      for (int i = 0; i < 10; i++) if (m_inq[i]) code = i;
      m_oerr = v ? 0 : 1;
      m_inc = 0;
      if (TE == 1) begin
        if (m_ref == DIV - 1) begin m_ref = 0; m_slot = 1 - m_slot; end
        else m_ref = m_ref + 1;
        m_seg = pat(m_slot == 1 ? m_tens : m_ones);
        m_an = (m_slot == 1) ? 2'b01 : 2'b10;
      end else begin
        m_seg = pat(m_ones);
        m_an = 2'b10;
      end
      if (v) begin
        m_run = (m_lastv && code == m_last) ? m_run + 1 : 1;
        if (code != m_ones && m_run == STB) begin
          if (code == (m_ones + 1) % 10) begin
            m_inc = 1;
            if (m_ones == 9 && TE == 1) m_tens = (m_tens + 1) % 10;
          end else if (code == 0) begin
            m_tens = 0;
          end else begin
            m_serr = 1;
          end
          m_ones = code;
        end
      end else begin
        m_run = 0;
      end
      m_lastv = v;
      m_last = code;
      m_inq = act;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("ones", 32'(digit_ones), 32'(m_ones));
      check("tens", 32'(digit_tens), 32'(m_tens));
      check("score_inc", 32'(score_inc), 32'(m_inc));
      check("onehot_err", 32'(onehot_err), 32'(m_oerr));
      check("seq_err", 32'(seq_err), 32'(m_serr));
      check("seg", 32'(seg), 32'(m_seg));
      check("an", 32'(an), 32'(m_an));
    end
  end

  always @(posedge clk) begin
    #1;
    if (score_inc === 1'b1) inc_cnt++;
    if (onehot_err === 1'b1) oerr_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  task automatic drive(input logic [9:0] v, input int n);
    act = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic step(input int d, input int n);
    logic [9:0] v;
    v = '0;
    v[d] = 1'b1;
    drive(v, n);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    logic [9:0] vec;
    int hold;
    int ones;
    int tens;
    int incs;
    int oerrs;
    int serr;
  } row_t;

  row_t tbl[$];

  function automatic void add(input logic [9:0] v, input int h, input int o, input int t,
                              input int i, input int e, input int s);
    row_t r;
    r.vec = v; r.hold = h; r.ones = o; r.tens = t; r.incs = i; r.oerrs = e; r.serr = s;
    tbl.push_back(r);
  endfunction

  initial begin
    int i0, e0, toggles;
    logic [1:0] prev_an;
    logic [9:0] one;

    add(10'b1, 5, 0, 0, 0, 1, 0);
    for (int k = 1; k < 10; k++) begin
      one = 10'b1 << k;
      add(one, 5, k, 0, 1, 0, 0);
    end
    add(10'b1, 5, 0, TE, 1, 0, 0);
    for (int k = 1; k < 5; k++) begin
      one = 10'b1 << k;
      add(one, 5, k, TE, 1, 0, 0);
    end
    add(10'b0000001000, 1, 4, TE, 0, 0, 0);
    add(10'b0000010000, 5, 4, TE, 0, 0, 0);
    add(10'b0000000000, 3, 4, TE, 0, 2, 0);
    add(10'b0000100100, 1, 4, TE, 0, 1, 0);
    add(10'b0000100000, 5, 5, TE, 1, 1, 0);

    rst = 1'b1;
    act = '0;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    check("reset_ones", 32'(digit_ones), 0);
    check("reset_an", 32'(an), 32'(2'b10));
    check("reset_seg", 32'(seg), 32'(7'b1000000));
    rst = 1'b0;

    foreach (tbl[r]) begin
      i0 = inc_cnt;
      e0 = oerr_cnt;
      drive(tbl[r].vec, tbl[r].hold);
      check($sformatf("row%0d_ones", r), 32'(digit_ones), 32'(tbl[r].ones));
      check($sformatf("row%0d_tens", r), 32'(digit_tens), 32'(tbl[r].tens));
      check($sformatf("row%0d_incs", r), 32'(inc_cnt - i0), 32'(tbl[r].incs));
      check($sformatf("row%0d_oerrs", r), 32'(oerr_cnt - e0), 32'(tbl[r].oerrs));
      check($sformatf("row%0d_serr", r), 32'(seq_err), 32'(tbl[r].serr));
    end

    // Game reset from 36, then an out-of-sequence jump.
    do_reset();
    step(0, 5);
    for (int n = 1; n <= 36; n++) step(n % 10, 4);
    check("at36_ones", 32'(digit_ones), 6);
    check("at36_tens", 32'(digit_tens), 32'(3 * TE));
    i0 = inc_cnt;
    step(0, 5);
    check("game_reset_tens", 32'(digit_tens), 0);
    check("game_reset_inc", 32'(inc_cnt - i0), 0);
    check("game_reset_serr", 32'(seq_err), 0);
    step(4, 5);
    check("jump_ones", 32'(digit_ones), 4);
    check("jump_serr", 32'(seq_err), 1);
    i0 = inc_cnt;
    step(5, 5);
    check("serr_sticky", 32'(seq_err), 1);
    check("after_jump_inc", 32'(inc_cnt - i0), 1);
    do_reset();
    check("serr_cleared", 32'(seq_err), 0);

    // Display multiplexing at 27.
    step(0, 5);
    for (int n = 1; n <= 27; n++) step(n % 10, 4);
    toggles = 0;
    prev_an = an;
    for (int c = 0; c < 17; c++) begin
      if (an == 2'b10) check("disp_seg_ones", 32'(seg), 32'(7'b1111000));
      else begin
        check("disp_an_val", 32'(an), 32'(2'b01));
        check("disp_seg_tens", 32'(seg), 32'(7'b0100100));
      end
      if (c > 0 && an != prev_an) toggles++;
      prev_an = an;
      @(negedge clk);
    end
    check("disp_toggles", 32'(toggles), 32'(4 * TE));

    // Randomized traffic, including occasional mid-run resets.
    for (int it = 0; it < 400; it++) begin
      int r, h;
      logic [9:0] v;
      r = $urandom_range(0, 9);
      h = $urandom_range(1, 4);
      v = '0;
      if (r < 6) v[(m_ones + 1) % 10] = 1'b1;
      else if (r < 8) v[$urandom_range(0, 9)] = 1'b1;
      else if (r == 8) v = 10'($urandom);
      if ($urandom_range(0, 49) == 0) begin
        rst = 1'b1;
        drive(v, 1);
        rst = 1'b0;
      end
      drive(v, h);
    end

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
